// File: rtl/fft_frame_reader.sv
// rtl/fft_frame_reader.sv - ping-pong capture of FFT output frames, re-serialised one bin per cycle
module fft_frame_reader #(
  parameter int LANES = 16,
  parameter int BEATS = 32,
  parameter int DW    = 13,
  parameter int IW    = 9
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid_in,
  input  logic [LANES*DW-1:0]   din_re,
  input  logic [LANES*DW-1:0]   din_im,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic signed [DW-1:0]  m_re,
  output logic signed [DW-1:0]  m_im,
  output logic [IW-1:0]         m_index,
  output logic                  m_last,
  output logic                  overflow,
  output logic                  err_short
);

  // Bin index = beat * LANES + lane, so the upper index bits select the
  // stored beat word and the lower bits select the lane within it.
  localparam int LW = $clog2(LANES);
  localparam int BW = $clog2(BEATS);
  localparam int AW = BW + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [IW-1:0] LAST_BIN  = IW'(LANES * BEATS - 1);

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DROP
  } wstate_t;

  // Writer state
  wstate_t         r_wstate;
  logic [BW-1:0]   r_beat_cnt;
  logic            r_wr_bank;
  logic            r_overflow;
  logic            r_err_short;

  // Shared bank occupancy and reader state
  logic [1:0]      r_full;
  logic            r_rd_bank;
  logic            r_m_valid;
  logic            r_m_last;
  logic [DW-1:0]   r_m_re;
  logic [DW-1:0]   r_m_im;
  logic [IW-1:0]   r_m_index;

  // One word per (bank, beat): a whole beat of lanes is written at once.
  logic [LANES*DW-1:0] r_mem_re [2*BEATS];
  logic [LANES*DW-1:0] r_mem_im [2*BEATS];

  logic            w_hs;
  logic            w_rd_done;
  logic            w_bank_free;
  logic            w_wr_en;
  logic            w_wr_done;
  logic [AW-1:0]   w_wr_addr;
  logic [1:0]      w_full_set;
  logic [1:0]      w_full_clr;
  logic            w_ld;
  logic            w_ld_bank;
  logic [IW-1:0]   w_ld_idx;
  logic [AW-1:0]   w_ld_addr;
  logic [LW-1:0]   w_ld_lane;
  logic [LANES*DW-1:0] w_word_re;
  logic [LANES*DW-1:0] w_word_im;

  assign w_hs      = r_m_valid & m_ready;
  assign w_rd_done = w_hs & r_m_last;

  // A bank being released by its final handshake this cycle counts as free,
  // so a new frame may start into it on the very same edge.
  assign w_bank_free = !r_full[r_wr_bank] || (w_rd_done && (r_rd_bank == r_wr_bank));

  assign w_wr_en   = valid_in &&
                     (((r_wstate == W_IDLE) && w_bank_free) || (r_wstate == W_FILL));
  assign w_wr_done = valid_in && (r_wstate == W_FILL) && (r_beat_cnt == LAST_BEAT);
  // beat_cnt is always zero in W_IDLE, so it addresses beat 0 there as well.
  assign w_wr_addr = {r_wr_bank, r_beat_cnt};

  assign w_full_set = {w_wr_done & r_wr_bank, w_wr_done & ~r_wr_bank};
  assign w_full_clr = {w_rd_done & r_rd_bank, w_rd_done & ~r_rd_bank};

  // Writer FSM: accepts, drops or abandons frames and emits the one-cycle error pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wstate    <= W_IDLE;
      r_beat_cnt  <= '0;
      r_wr_bank   <= 1'b0;
      r_overflow  <= 1'b0;
      r_err_short <= 1'b0;
    end else begin
      r_overflow  <= 1'b0;
      r_err_short <= 1'b0;
      case (r_wstate)
        W_IDLE: begin
          if (valid_in) begin
            if (w_bank_free) begin
              r_beat_cnt <= BW'(1);
              r_wstate   <= W_FILL;
            end else begin
              r_overflow <= 1'b1;
              r_wstate   <= W_DROP;
            end
          end
        end
        W_FILL: begin
          if (!valid_in) begin
            // Partial frame: the bank stays empty and is reused by the next frame.
            r_err_short <= 1'b1;
            r_beat_cnt  <= '0;
            r_wstate    <= W_IDLE;
          end else if (r_beat_cnt == LAST_BEAT) begin
            r_wr_bank  <= ~r_wr_bank;
            r_beat_cnt <= '0;
            r_wstate   <= W_IDLE;
          end else begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
          end
        end
        W_DROP: begin
          if (!valid_in) begin
            r_wstate <= W_IDLE;
          end
        end
        default: begin
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  // Bank full flags: set by the writer on the last beat, cleared by the reader on the last bin
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full & ~w_full_clr) | w_full_set;
    end
  end

  // Frame buffer write port; contents are not reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_re[w_wr_addr] <= din_re;
      r_mem_im[w_wr_addr] <= din_im;
    end
  end

  // Choose which bin (if any) the output register loads on this edge
  always_comb begin
    w_ld      = 1'b0;
    w_ld_bank = r_rd_bank;
    w_ld_idx  = '0;
    if (w_hs && !r_m_last) begin
      w_ld     = 1'b1;
      w_ld_idx = r_m_index + IW'(1);
    end else if (w_rd_done) begin
      // Chain straight into the other bank when it already holds a frame.
      w_ld      = r_full[~r_rd_bank];
      w_ld_bank = ~r_rd_bank;
    end else if (!r_m_valid && r_full[r_rd_bank]) begin
      w_ld = 1'b1;
    end
  end

  assign w_ld_addr = {w_ld_bank, w_ld_idx[IW-1:LW]};
  assign w_ld_lane = w_ld_idx[LW-1:0];
  assign w_word_re = r_mem_re[w_ld_addr];
  assign w_word_im = r_mem_im[w_ld_addr];

  // Reader output register: holds while stalled, advances one bin per handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_bank <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_re    <= '0;
      r_m_im    <= '0;
      r_m_index <= '0;
    end else begin
      if (w_rd_done) begin
        r_rd_bank <= ~r_rd_bank;
      end
      if (w_ld) begin
        r_m_valid <= 1'b1;
        r_m_re    <= w_word_re[int'(w_ld_lane)*DW +: DW];
        r_m_im    <= w_word_im[int'(w_ld_lane)*DW +: DW];
        r_m_index <= w_ld_idx;
        r_m_last  <= (w_ld_idx == LAST_BIN);
      end else if (w_hs) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_valid   = r_m_valid;
  assign m_re      = r_m_re;
  assign m_im      = r_m_im;
  assign m_index   = r_m_index;
  assign m_last    = r_m_last;
  assign overflow  = r_overflow;
  assign err_short = r_err_short;

endmodule

// File: tb/tb_fft_frame_reader.sv
// tb/tb_fft_frame_reader.sv - self-checking bench for fft_frame_reader
`timescale 1ns/1ps
module tb_fft_frame_reader;

  localparam int LANES = 16;
  localparam int BEATS = 32;
  localparam int DW    = 13;
  localparam int IW    = 9;
  localparam int NBIN  = LANES * BEATS;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 valid_in = 1'b0;
  logic                 m_ready = 1'b0;
  logic [LANES*DW-1:0]  din_re = '0;
  logic [LANES*DW-1:0]  din_im = '0;
  logic                 m_valid;
  logic signed [DW-1:0] m_re;
  logic signed [DW-1:0] m_im;
  logic [IW-1:0]        m_index;
  logic                 m_last;
  logic                 overflow;
  logic                 err_short;

  fft_frame_reader #(
    .LANES(LANES),
    .BEATS(BEATS),
    .DW(DW),
    .IW(IW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .valid_in(valid_in),
    .din_re(din_re),
    .din_im(din_im),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_re(m_re),
    .m_im(m_im),
    .m_index(m_index),
    .m_last(m_last),
    .overflow(overflow),
    .err_short(err_short)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [IW-1:0] idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } bin_t;

  // Reference: the expected output stream is simply every accepted frame,
  // in acceptance order, bins 0..511 with data exactly as sent.
  bin_t          exp_q[$];
  bin_t          got_q[$];
  int            got_cyc[$];
  int            got_rd = 0;
  logic [DW-1:0] cur_re [NBIN];
  logic [DW-1:0] cur_im [NBIN];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ovf_cnt  = 0;
  int err_cnt  = 0;
  int ready_mode = 2;  // 0: always ready, 1: random, 2: driven by the test

  // Output monitor: records accepted bins and counts pulse cycles
  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (overflow)  ovf_cnt++;
      if (err_short) err_cnt++;
      if (m_valid && m_ready) begin
        got_q.push_back({m_last, m_index, m_re, m_im});
        got_cyc.push_back(cyc);
      end
    end
  end

  // Advance one clock; also checks that a stalled bin is held unchanged
  task automatic step();
    logic pv, pr, prst;
    bin_t pb;
    pv   = m_valid;
    pr   = m_ready;
    prst = rstn;
    pb   = {m_last, m_index, m_re, m_im};
    @(posedge clk);
    #1;
    if (prst && rstn && pv && !pr) begin
      n_checks++;
      if (m_valid !== 1'b1 || {m_last, m_index, m_re, m_im} !== pb)
        $display("FAIL stall_hold: got valid=%0b idx=%0d re=%0d im=%0d, need valid=1 idx=%0d re=%0d im=%0d",
                 m_valid, m_index, m_re, m_im, pb.idx, $signed(pb.re), $signed(pb.im));
      else
        n_pass++;
    end
    if (ready_mode == 0)
      m_ready = 1'b1;
    else if (ready_mode == 1)
      m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic make_frame(input int kind, input int tag);
    for (int i = 0; i < NBIN; i++) begin
      case (kind)
        0: begin
          cur_re[i] = DW'(i);
          cur_im[i] = DW'(-i);
        end
        1: begin
          cur_re[i] = DW'(tag);
          cur_im[i] = DW'($urandom);
        end
        default: begin
          cur_re[i] = DW'($urandom);
          cur_im[i] = DW'($urandom);
        end
      endcase
    end
  endtask

  task automatic expect_frame();
    bin_t b;
    for (int i = 0; i < NBIN; i++) begin
      b.last = (i == NBIN - 1);
      b.idx  = IW'(i);
      b.re   = cur_re[i];
      b.im   = cur_im[i];
      exp_q.push_back(b);
    end
  endtask

  task automatic send_frame(input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      valid_in = 1'b1;
      for (int l = 0; l < LANES; l++) begin
        din_re[l*DW +: DW] = cur_re[b*LANES + l];
        din_im[l*DW +: DW] = cur_im[b*LANES + l];
      end
      step();
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (!((got_q.size() - got_rd >= exp_q.size()) && !m_valid) && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= budget)
      $display("FAIL %s_drain_timeout: got %0d bins, need %0d within %0d cycles",
               name, got_q.size() - got_rd, exp_q.size(), budget);
    else
      n_pass++;
    repeat (4) step();
  endtask

  task automatic compare_stream(input string name);
    int ng, bad;
    bin_t g, e;
    ng  = got_q.size() - got_rd;
    bad = -1;
    n_checks++;
    if (ng != exp_q.size())
      $display("FAIL %s_count: got %0d bins, need %0d", name, ng, exp_q.size());
    else
      n_pass++;
    for (int i = 0; i < ng && i < exp_q.size(); i++) begin
      if (got_q[got_rd + i] !== exp_q[i]) begin
        bad = i;
        break;
      end
    end
    n_checks++;
    if (bad >= 0) begin
      g = got_q[got_rd + bad];
      e = exp_q[bad];
      $display("FAIL %s_data at bin %0d: got idx=%0d re=%0d im=%0d last=%0b, need idx=%0d re=%0d im=%0d last=%0b",
               name, bad, g.idx, $signed(g.re), $signed(g.im), g.last,
               e.idx, $signed(e.re), $signed(e.im), e.last);
    end else begin
      n_pass++;
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic check_pulses(input string name, input int ov0, input int er0,
                              input int ov_need, input int er_need);
    n_checks++;
    if (ovf_cnt - ov0 != ov_need || err_cnt - er0 != er_need)
      $display("FAIL %s_pulses: got overflow=%0d err_short=%0d cycles, need %0d and %0d",
               name, ovf_cnt - ov0, err_cnt - er0, ov_need, er_need);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    ready_mode = 2;
    rstn = 1'b0;
    valid_in = 1'b0;
    m_ready = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({m_valid, m_last, overflow, err_short} !== 4'b0)
      $display("FAIL reset_ctrl: got valid=%0b last=%0b ovf=%0b err=%0b, need all 0",
               m_valid, m_last, overflow, err_short);
    else
      n_pass++;
    n_checks++;
    if (m_re !== 0 || m_im !== 0 || m_index !== 0)
      $display("FAIL reset_data: got re=%0d im=%0d idx=%0d, need 0 0 0", m_re, m_im, m_index);
    else
      n_pass++;
    rstn = 1'b1;
    repeat (2) step();
    n_checks++;
    if (m_valid !== 1'b0)
      $display("FAIL reset_idle: got m_valid=%0b, need 0", m_valid);
    else
      n_pass++;
  endtask

  task automatic test_single_frame();
    int ov0, er0, span;
    ov0 = ovf_cnt;
    er0 = err_cnt;
    ready_mode = 0;
    m_ready = 1'b1;
    make_frame(0, 0);
    expect_frame();
    send_frame(BEATS);
    n_checks++;
    if (m_valid !== 1'b0)
      $display("FAIL single_latency_early: got m_valid=%0b one edge after beat 31, need 0", m_valid);
    else
      n_pass++;
    step();
    n_checks++;
    if (m_valid !== 1'b1 || m_index !== 0 || m_re !== 0 || m_im !== 0)
      $display("FAIL single_latency: got valid=%0b idx=%0d re=%0d im=%0d, need 1 0 0 0",
               m_valid, m_index, m_re, m_im);
    else
      n_pass++;
    wait_drain("single", 2000);
    span = (got_q.size() - got_rd >= NBIN) ? got_cyc[got_rd + NBIN - 1] - got_cyc[got_rd] : -1;
    n_checks++;
    if (span != NBIN - 1)
      $display("FAIL single_consecutive: got span %0d cycles, need %0d", span, NBIN - 1);
    else
      n_pass++;
    compare_stream("single");
    check_pulses("single", ov0, er0, 0, 0);
  endtask

  task automatic test_backpressure();
    int ov0, er0;
    ov0 = ovf_cnt;
    er0 = err_cnt;
    ready_mode = 1;
    make_frame(0, 0);
    expect_frame();
    send_frame(BEATS);
    wait_drain("backpressure", 8000);
    compare_stream("backpressure");
    check_pulses("backpressure", ov0, er0, 0, 0);
  endtask

  task automatic test_pingpong_overflow();
    int ov0, er0;
    ov0 = ovf_cnt;
    er0 = err_cnt;
    ready_mode = 0;
    m_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      make_frame(1, f);
      if (f < 2) expect_frame();
      send_frame(BEATS);
    end
    wait_drain("pingpong", 4000);
    compare_stream("pingpong");
    check_pulses("pingpong", ov0, er0, 1, 0);
  endtask

  task automatic test_boundary_free();
    int ov0, er0, n;
    ov0 = ovf_cnt;
    er0 = err_cnt;
    ready_mode = 2;
    m_ready = 1'b0;
    make_frame(2, 0);
    expect_frame();
    send_frame(BEATS);
    make_frame(2, 0);
    expect_frame();
    send_frame(BEATS);
    repeat (5) step();
    m_ready = 1'b1;
    n = 0;
    while (!(m_valid && m_index == IW'(NBIN - 1)) && n < 2000) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= 2000)
      $display("FAIL boundary_reach_511: got idx=%0d valid=%0b after %0d cycles, need idx 511",
               m_index, m_valid, n);
    else
      n_pass++;
    make_frame(2, 0);
    expect_frame();
    send_frame(BEATS);
    wait_drain("boundary", 4000);
    compare_stream("boundary");
    check_pulses("boundary", ov0, er0, 0, 0);
  endtask

  task automatic test_short_frame();
    int ov0, er0;
    ov0 = ovf_cnt;
    er0 = err_cnt;
    ready_mode = 0;
    m_ready = 1'b1;
    make_frame(2, 0);
    send_frame(20);
    step();
    n_checks++;
    if (err_short !== 1'b1 || overflow !== 1'b0)
      $display("FAIL short_pulse: got err_short=%0b overflow=%0b, need 1 0", err_short, overflow);
    else
      n_pass++;
    step();
    n_checks++;
    if (err_short !== 1'b0)
      $display("FAIL short_pulse_width: got err_short=%0b, need 0", err_short);
    else
      n_pass++;
    repeat (2) step();
    make_frame(2, 0);
    expect_frame();
    send_frame(BEATS);
    wait_drain("short", 2000);
    compare_stream("short");
    check_pulses("short", ov0, er0, 0, 1);
  endtask

  task automatic test_reset_mid_drain();
    int n;
    ready_mode = 0;
    m_ready = 1'b1;
    make_frame(2, 0);
    send_frame(BEATS);
    n = 0;
    while (!(m_valid && m_index == IW'(100)) && n < 1000) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= 1000)
      $display("FAIL middrain_reach_100: got idx=%0d after %0d cycles, need 100", m_index, n);
    else
      n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({m_valid, m_last, overflow, err_short} !== 4'b0 || m_re !== 0 || m_im !== 0 || m_index !== 0)
      $display("FAIL middrain_reset: got valid=%0b idx=%0d re=%0d im=%0d last=%0b, need all 0",
               m_valid, m_index, m_re, m_im, m_last);
    else
      n_pass++;
    repeat (3) step();
    rstn = 1'b1;
    repeat (3) step();
    got_rd = got_q.size();
    n_checks++;
    if (m_valid !== 1'b0)
      $display("FAIL middrain_flushed: got m_valid=%0b after release, need 0", m_valid);
    else
      n_pass++;
    make_frame(2, 0);
    expect_frame();
    send_frame(BEATS);
    wait_drain("middrain", 2000);
    compare_stream("middrain");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_pingpong_overflow();
    test_boundary_free();
    test_short_frame();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
